byte_sram_mailbox: RTL and testbench
====================================

// Module: byte_sram_mailbox
// PURPOSE
//  Parametrised byte-enable synchronous SRAM with a valid/ready request channel and a
//  registered read response. Serves as the IM/DM model for the pipeline CPU.
//  Includes a sticky "done" mailbox: it latches when the program writes DONE_VAL to
//  byte address DONE_ADDR. Saturating access counters support bench reporting.
// PARAMETERS
//  DATA_W     32        word width; must be a multiple of 8. NB = DATA_W/8 byte lanes.
//  ADDR_W     16        byte-address width.
//  DEPTH      16384     number of words implemented (<= 2**(ADDR_W-log2(NB))).
//  DONE_ADDR  16'hFFFC  byte address of the completion mailbox.
//  DONE_VAL   8'hFF     byte value that signals completion.
//  CNT_W      32        width of the access counters.
// PORTS
//  clk         in   1       clock, rising edge
//  rst         in   1       asynchronous reset, active-low
//  req_valid   in   1       request present
//  req_ready   out  1       request accepted when req_valid & req_ready
//  w_en        in   NB      byte write enables; nonzero = write, zero = read
//  address     in   ADDR_W  byte address; low log2(NB) bits ignored (word aligned)
//  write_data  in   DATA_W  write data; lane i = write_data[8i+7:8i] (little-endian)
//  rsp_valid   out  1       read data valid
//  rsp_ready   in   1       consumer accepts read data
//  read_data   out  DATA_W  read data
//  done        out  1       sticky completion flag
//  rd_cnt      out  CNT_W   accepted reads, saturating
//  wr_cnt      out  CNT_W   accepted writes, saturating
// BEHAVIOUR
//  - Reset (rst=0, asynchronous): rsp_valid=0, read_data=0, done=0, rd_cnt=0, wr_cnt=0.
//    Memory contents are not reset. Reset mid-read drops the pending response.
//  - Word index = address[ADDR_W-1:log2(NB)]. Only indices < DEPTH are backed by storage.
//  - req_ready = !rsp_valid | rsp_ready. At most one request is accepted per cycle.
//  - Write (accepted, w_en!=0): lanes with w_en[i]=1 are updated at the clock edge.
//    Other lanes are unchanged. No response is produced; rsp_valid is unaffected.
//  - Read (accepted, w_en==0): at the next edge, rsp_valid=1 and read_data=mem[idx].
//    Latency is 1 cycle. A read of a word written in the previous cycle returns the
//    new data.
//  - Response hold: while rsp_valid & !rsp_ready, read_data and rsp_valid stay stable
//    and req_ready=0. rsp_valid clears on rsp_ready unless a new read is accepted in
//    the same cycle (back-to-back reads give continuous rsp_valid).
//  - done: set on an accepted write whose lane covering DONE_ADDR is enabled and
//    carries DONE_VAL. It stays set until reset; later writes do not clear it.
//  - Counters: increment on each accepted read/write and saturate at all-ones
//    (no wrap).
//  - Out-of-range index (>= DEPTH): see CONFIGURATION.
// CONFIGURATION
//  Macro SRAM_OOR_ERR_EN:
//   defined: adds output oor_err (1 bit, reset 0). An out-of-range access pulses
//     oor_err for 1 cycle. A write is suppressed (done is still evaluated). A read
//     responds with read_data=0. Counters still increment.
//   undefined: no oor_err port. The index wraps modulo DEPTH (upper bits ignored).
// TESTING
//  1 Reset: hold rst=0 for 2 cycles with random inputs -> all outputs 0. Release ->
//    req_ready=1.
//  2 Byte write: write 32'hAABBCCDD @0x10 with w_en=4'hF, then 32'h11223344 @0x10
//    with w_en=4'b0101 -> read @0x10 returns 32'hAA22CC44 one cycle after accept.
//  3 Backpressure: read @0x10 with rsp_ready=0 for 3 cycles -> rsp_valid=1,
//    read_data stable, req_ready=0. Raise rsp_ready -> next request accepted.
//  4 Mailbox: write 32'h00000000 @0xFFFC w_en=4'h1 -> done=0. Write 32'h000000FF
//    w_en=4'h1 -> done=1 next cycle. Write 0 again -> done stays 1.
//  5 Counters: CNT_W=2, issue 5 reads -> rd_cnt=3 (saturated), wr_cnt=0.
//  6 OOR (DEPTH=16): SRAM_OOR_ERR_EN -> write @0x40 pulses oor_err and read @0x40
//    returns 0. Without the macro, a read @0x40 returns mem[0].

Source files
------------

// File: rtl/byte_sram_mailbox.sv
// Byte-enable synchronous SRAM with valid/ready request, registered read response,
// sticky completion mailbox and saturating access counters. Optional macro: SRAM_OOR_ERR_EN.
module byte_sram_mailbox #(
    parameter int                DATA_W    = 32,
    parameter int                ADDR_W    = 16,
    parameter int                DEPTH     = 16384,
    parameter logic [ADDR_W-1:0] DONE_ADDR = 16'hFFFC,
    parameter logic [7:0]        DONE_VAL  = 8'hFF,
    parameter int                CNT_W     = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [DATA_W/8-1:0]     w_en,
    input  logic [ADDR_W-1:0]       address,
    input  logic [DATA_W-1:0]       write_data,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_W-1:0]       read_data,
    output logic                    done,
`ifdef SRAM_OOR_ERR_EN
    output logic                    oor_err,
`endif
    output logic [CNT_W-1:0]        rd_cnt,
    output logic [CNT_W-1:0]        wr_cnt
);

    localparam int NB        = DATA_W / 8;
    localparam int OFF_W     = $clog2(NB);
    localparam int IDX_W     = ADDR_W - OFF_W;
    localparam int MEM_AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int DONE_LANE = int'(DONE_ADDR[OFF_W-1:0]);
    localparam logic [ADDR_W-1:0] WORD_MASK = {{IDX_W{1'b1}}, {OFF_W{1'b0}}};

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic                rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   read_data_q, read_data_d;
    logic                done_q, done_d;
    logic [CNT_W-1:0]    rd_cnt_q, rd_cnt_d;
    logic [CNT_W-1:0]    wr_cnt_q, wr_cnt_d;
`ifdef SRAM_OOR_ERR_EN
    logic                oor_err_q, oor_err_d;
    logic                oor_s;
`endif

    logic                accept_s, rd_s, wr_s, mem_we_s, done_hit_s;
    logic [IDX_W-1:0]    idx_s;
    logic [31:0]         idx_ext_s;
    logic [MEM_AW-1:0]   mem_idx_s;
    logic [DATA_W-1:0]   mem_rdata_s;

    // Request decode, word indexing and mailbox match
    always_comb begin
        req_ready  = ~rsp_valid_q | rsp_ready;
        accept_s   = req_valid & req_ready;
        rd_s       = accept_s & ~(|w_en);
        wr_s       = accept_s & (|w_en);
        idx_s      = address[ADDR_W-1:OFF_W];
        idx_ext_s  = 32'(idx_s);
        // Without the range check, out-of-range indices alias modulo DEPTH.
        mem_idx_s  = MEM_AW'(idx_ext_s % 32'(DEPTH));
        done_hit_s = wr_s
                   & ((address & WORD_MASK) == (DONE_ADDR & WORD_MASK))
                   & w_en[DONE_LANE]
                   & (write_data[8*DONE_LANE +: 8] == DONE_VAL);
`ifdef SRAM_OOR_ERR_EN
        oor_s       = (idx_ext_s >= 32'(DEPTH));
        mem_we_s    = wr_s & ~oor_s;
        mem_rdata_s = oor_s ? {DATA_W{1'b0}} : mem_q[mem_idx_s];
`else
        mem_we_s    = wr_s;
        mem_rdata_s = mem_q[mem_idx_s];
`endif
    end

    // Next-state for response channel, mailbox and counters
    always_comb begin
        rsp_valid_d = rsp_valid_q;
        read_data_d = read_data_q;
        done_d      = done_q | done_hit_s;
        rd_cnt_d    = rd_cnt_q;
        wr_cnt_d    = wr_cnt_q;
        if (rd_s) begin
            rsp_valid_d = 1'b1;
            read_data_d = mem_rdata_s;
        end else if (rsp_ready) begin
            rsp_valid_d = 1'b0;
        end else begin
            rsp_valid_d = rsp_valid_q;
        end
        if (rd_s && (rd_cnt_q != {CNT_W{1'b1}})) begin
            rd_cnt_d = rd_cnt_q + CNT_W'(1);
        end else begin
            rd_cnt_d = rd_cnt_q;
        end
        if (wr_s && (wr_cnt_q != {CNT_W{1'b1}})) begin
            wr_cnt_d = wr_cnt_q + CNT_W'(1);
        end else begin
            wr_cnt_d = wr_cnt_q;
        end
`ifdef SRAM_OOR_ERR_EN
        oor_err_d = accept_s & oor_s;
`endif
    end

    // Control and response registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rsp_valid_q <= 1'b0;
            read_data_q <= {DATA_W{1'b0}};
            done_q      <= 1'b0;
            rd_cnt_q    <= {CNT_W{1'b0}};
            wr_cnt_q    <= {CNT_W{1'b0}};
`ifdef SRAM_OOR_ERR_EN
            oor_err_q   <= 1'b0;
`endif
        end else begin
            rsp_valid_q <= rsp_valid_d;
            read_data_q <= read_data_d;
            done_q      <= done_d;
            rd_cnt_q    <= rd_cnt_d;
            wr_cnt_q    <= wr_cnt_d;
`ifdef SRAM_OOR_ERR_EN
            oor_err_q   <= oor_err_d;
`endif
        end
    end

    // Storage array: byte-lane writes, contents survive reset
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            for (int i = 0; i < NB; i++) begin
                if (w_en[i]) begin
                    mem_q[mem_idx_s][8*i +: 8] <= write_data[8*i +: 8];
                end
            end
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign read_data = read_data_q;
    assign done      = done_q;
    assign rd_cnt    = rd_cnt_q;
    assign wr_cnt    = wr_cnt_q;
`ifdef SRAM_OOR_ERR_EN
    assign oor_err   = oor_err_q;
`endif

endmodule

// File: tb/tb_byte_sram_mailbox.sv
// Directed bench for byte_sram_mailbox (DEPTH=16, CNT_W=2); honours SRAM_OOR_ERR_EN.
module tb_byte_sram_mailbox;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  w_en;
    logic [15:0] address;
    logic [31:0] write_data;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] read_data;
    logic        done;
    logic [1:0]  rd_cnt;
    logic [1:0]  wr_cnt;
`ifdef SRAM_OOR_ERR_EN
    logic        oor_err;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    byte_sram_mailbox #(
        .DATA_W    (32),
        .ADDR_W    (16),
        .DEPTH     (16),
        .DONE_ADDR (16'hFFFC),
        .DONE_VAL  (8'hFF),
        .CNT_W     (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .w_en       (w_en),
        .address    (address),
        .write_data (write_data),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .read_data  (read_data),
        .done       (done),
`ifdef SRAM_OOR_ERR_EN
        .oor_err    (oor_err),
`endif
        .rd_cnt     (rd_cnt),
        .wr_cnt     (wr_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [3:0] we, input logic [15:0] a,
                         input logic [31:0] d, input logic rr);
        req_valid  = v;
        w_en       = we;
        address    = a;
        write_data = d;
        rsp_ready  = rr;
        #1;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset held with random inputs
        rst = 1'b0;
        drive(1'($urandom), 4'($urandom), 16'($urandom), $urandom, 1'($urandom));
        cyc();
        drive(1'($urandom), 4'($urandom), 16'($urandom), $urandom, 1'($urandom));
        cyc();
        chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rst_read_data", read_data, 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_rd_cnt", 32'(rd_cnt), 32'h0);
        chk("rst_wr_cnt", 32'(wr_cnt), 32'h0);
`ifdef SRAM_OOR_ERR_EN
        chk("rst_oor_err", 32'(oor_err), 32'h0);
`endif
        drive(1'b0, 4'h0, 16'h0000, 32'h0, 1'b1);
        rst = 1'b1;
        #1;
        chk("rel_req_ready", 32'(req_ready), 32'h1);
        cyc();

        // Byte-lane writes then read
        drive(1'b1, 4'hF, 16'h0010, 32'hAABBCCDD, 1'b1);
        cyc();
        chk("wr_no_rsp", 32'(rsp_valid), 32'h0);
        chk("wr_cnt_1", 32'(wr_cnt), 32'h1);
        drive(1'b1, 4'h5, 16'h0010, 32'h11223344, 1'b1);
        cyc();
        drive(1'b1, 4'h0, 16'h0010, 32'h0, 1'b1);
        chk("rd_pre_valid", 32'(rsp_valid), 32'h0);
        cyc();
        chk("rd_valid", 32'(rsp_valid), 32'h1);
        chk("rd_merge", read_data, 32'hAA22CC44);
        chk("rd_cnt_1", 32'(rd_cnt), 32'h1);
        chk("wr_cnt_2", 32'(wr_cnt), 32'h2);

        // Backpressure
        drive(1'b1, 4'hF, 16'h0014, 32'h55667788, 1'b1);
        cyc();
        chk("wr_clears_rsp", 32'(rsp_valid), 32'h0);
        chk("wr_cnt_3", 32'(wr_cnt), 32'h3);
        drive(1'b1, 4'h0, 16'h0010, 32'h0, 1'b0);
        cyc();
        chk("bp_valid", 32'(rsp_valid), 32'h1);
        chk("bp_data", read_data, 32'hAA22CC44);
        drive(1'b1, 4'h0, 16'h0014, 32'h0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            chk("bp_req_ready", 32'(req_ready), 32'h0);
            cyc();
            chk("bp_hold_valid", 32'(rsp_valid), 32'h1);
            chk("bp_hold_data", read_data, 32'hAA22CC44);
        end
        chk("bp_rd_cnt", 32'(rd_cnt), 32'h2);
        drive(1'b1, 4'h0, 16'h0014, 32'h0, 1'b1);
        chk("bp_release_ready", 32'(req_ready), 32'h1);
        cyc();
        chk("b2b_valid", 32'(rsp_valid), 32'h1);
        chk("b2b_data", read_data, 32'h55667788);
        chk("rd_cnt_sat", 32'(rd_cnt), 32'h3);
        drive(1'b0, 4'h0, 16'h0000, 32'h0, 1'b1);
        cyc();
        chk("rsp_drain", 32'(rsp_valid), 32'h0);

        // Mailbox
        drive(1'b1, 4'h1, 16'hFFFC, 32'h00000000, 1'b1);
        cyc();
        chk("mb_zero", 32'(done), 32'h0);
        drive(1'b1, 4'hE, 16'hFFFC, 32'h000000FF, 1'b1);
        cyc();
        chk("mb_lane_off", 32'(done), 32'h0);
        drive(1'b1, 4'h1, 16'hFFF8, 32'h000000FF, 1'b1);
        cyc();
        chk("mb_wrong_addr", 32'(done), 32'h0);
        drive(1'b1, 4'h1, 16'hFFFC, 32'h000000FF, 1'b1);
        chk("mb_pre_set", 32'(done), 32'h0);
        cyc();
        chk("mb_set", 32'(done), 32'h1);
        drive(1'b1, 4'h1, 16'hFFFC, 32'h00000000, 1'b1);
        cyc();
        chk("mb_sticky", 32'(done), 32'h1);
        chk("wr_cnt_sat", 32'(wr_cnt), 32'h3);

        // Counter saturation from a fresh reset
        drive(1'b0, 4'h0, 16'h0000, 32'h0, 1'b1);
        rst = 1'b0;
        #1;
        chk("rst2_done", 32'(done), 32'h0);
        chk("rst2_rd_cnt", 32'(rd_cnt), 32'h0);
        chk("rst2_wr_cnt", 32'(wr_cnt), 32'h0);
        cyc();
        rst = 1'b1;
        cyc();
        for (int k = 1; k <= 5; k++) begin
            drive(1'b1, 4'h0, 16'h0010, 32'h0, 1'b1);
            cyc();
            chk("cnt_rd", 32'(rd_cnt), (k < 3) ? 32'(k) : 32'h3);
            chk("cnt_data", read_data, 32'hAA22CC44);
        end
        drive(1'b0, 4'h0, 16'h0000, 32'h0, 1'b1);
        cyc();
        chk("cnt_wr_zero", 32'(wr_cnt), 32'h0);

        // Out-of-range index
        drive(1'b1, 4'hF, 16'h0000, 32'hCAFEBABE, 1'b1);
        cyc();
`ifdef SRAM_OOR_ERR_EN
        drive(1'b1, 4'hF, 16'h0040, 32'h12345678, 1'b1);
        cyc();
        chk("oor_wr_pulse", 32'(oor_err), 32'h1);
        drive(1'b0, 4'h0, 16'h0000, 32'h0, 1'b1);
        cyc();
        chk("oor_pulse_end", 32'(oor_err), 32'h0);
        drive(1'b1, 4'h0, 16'h0040, 32'h0, 1'b1);
        cyc();
        chk("oor_rd_valid", 32'(rsp_valid), 32'h1);
        chk("oor_rd_zero", read_data, 32'h0);
        chk("oor_rd_pulse", 32'(oor_err), 32'h1);
        drive(1'b1, 4'h0, 16'h0000, 32'h0, 1'b1);
        cyc();
        chk("oor_wr_suppressed", read_data, 32'hCAFEBABE);
        chk("oor_inrange_quiet", 32'(oor_err), 32'h0);
`else
        drive(1'b1, 4'h0, 16'h0040, 32'h0, 1'b1);
        cyc();
        chk("wrap_rd", read_data, 32'hCAFEBABE);
        drive(1'b1, 4'hF, 16'h0044, 32'hDEADBEEF, 1'b1);
        cyc();
        drive(1'b1, 4'h0, 16'h0004, 32'h0, 1'b1);
        cyc();
        chk("wrap_wr", read_data, 32'hDEADBEEF);
`endif
        drive(1'b0, 4'h0, 16'h0000, 32'h0, 1'b1);
        cyc();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
